// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and the
// baud-divider rule used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_OVS      = 16;
  localparam int UART_SAMP_A   = 7;
  localparam int UART_SAMP_B   = 8;
  localparam int UART_DECIDE   = 9;
  localparam int UART_BITS     = 8;

  // Clock cycles per oversample tick, truncated and never below one.
  function automatic int uart_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * UART_OVS);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// clr holds the count at zero so the tick phase restarts when clr is released.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    // NOTE: a default assignment before any branch keeps this block from inferring a latch.
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority voting and a single-byte
// holding register presented through a valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int SW  = $clog2(OVS);

  localparam logic [SW-1:0] S_A      = SW'(UART_SAMP_A);
  localparam logic [SW-1:0] S_B      = SW'(UART_SAMP_B);
  localparam logic [SW-1:0] S_DECIDE = SW'(UART_DECIDE);
  localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_BITS - 1);

  rx_state_t     state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic       sync1_q, sync2_q;
  logic [1:0] sync_vld_q;
  logic       rx_s;
  logic       tick;
  logic       vote;
  logic       bit_strobe;
  logic       stop_strobe;

  // Flops reset to the idle level; sync_vld_q marks when they carry real pin samples, so
  // the forced ones at reset release can never arm start detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign rx_s = sync2_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  assign vote = maj3(samp_q[0], samp_q[1], rx_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic. IDLE watches the line every clock; other states move on ticks only.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        s_d   = '0;
        bit_d = '0;
        if (rx_s && sync_vld_q[1]) begin
          armed_d = 1'b1;
        end else if (!rx_s && armed_q) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: if (tick) begin
        s_d = s_q + 1'b1;
        if (s_q == S_DECIDE && vote) state_d = IDLE;
        else if (s_q == S_LAST)      state_d = DATA;
      end
      DATA: if (tick) begin
        s_d = s_q + 1'b1;
        if (s_q == S_LAST) begin
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        s_d = s_q + 1'b1;
        if (s_q == S_DECIDE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bit_strobe  = (state_q == DATA) && tick && (s_q == S_DECIDE);
  assign stop_strobe = (state_q == STOP) && tick && (s_q == S_DECIDE);

  // Output logic: sample capture, shift register and the holding-register handshake.
  always_comb begin
    samp_d  = samp_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (tick && state_q != IDLE) begin
      if (s_q == S_A) samp_d[0] = rx_s;
      if (s_q == S_B) samp_d[1] = rx_s;
    end

    if (bit_strobe) shift_d = {vote, shift_q[7:1]};

    // A handshake in the decision cycle frees the slot, so the new byte is not an overrun.
    if (stop_strobe) begin
      if (!vote) begin
        ferr_d = 1'b1;
      end else if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized traffic,
// compared every cycle against a frame-level model of the receiver's outputs.
module tb_uart_rx;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int BITC   = 16;          // clk per bit with DIV=1
  // Pin start edge to registered stop decision: 2 sync + 1 detect + 16 start
  // + 8*16 data + 10 stop samples (s=0..9).
  localparam int LAT    = 2 + 1 + 16 + 8 * 16 + 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each properly sent frame schedules one stop decision LAT edges after
  // its start edge; the decision delivers, overruns or flags a framing error.
  int unsigned cyc = 0;
  int unsigned ev_edge [256];
  logic [7:0]  ev_data [256];
  logic        ev_ok   [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  always @(posedge clk) begin : model
    logic       v;
    logic [7:0] d;
    logic       fe;
    logic       ov;
    v  = m_valid;
    d  = m_data;
    fe = 1'b0;
    ov = 1'b0;
    cyc <= cyc + 1;
    if (rst) begin
      v = 1'b0;
      d = 8'h00;
      rd_ptr <= wr_ptr;
    end else begin
      if (v && rx_ready) v = 1'b0;
      if (rd_ptr < wr_ptr && ev_edge[rd_ptr] == cyc + 1) begin
        if (!ev_ok[rd_ptr]) fe = 1'b1;
        else if (!v) begin
          d = ev_data[rd_ptr];
          v = 1'b1;
        end else ov = 1'b1;
        rd_ptr <= rd_ptr + 1;
      end
    end
    m_valid <= v;
    m_data  <= d;
    m_ferr  <= fe;
    m_ovr   <= ov;
  end

  // Compare process plus observation counters used by the directed literal checks.
  int          ferr_cnt = 0;
  int          ovr_cnt  = 0;
  int          hs_cnt   = 0;
  logic [7:0]  hs_data  = 8'h00;
  int unsigned rise_cyc = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      check("rx_valid vs model", rx_valid, m_valid);
      check("rx_data vs model", rx_data, m_data);
      check("frame_err vs model", frame_err, m_ferr);
      check("overrun vs model", overrun, m_ovr);
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && rx_ready) begin
      hs_cnt++;
      hs_data = rx_data;
    end
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  logic rand_rdy = 1'b0;

  task automatic drive_cycle(input logic pin);
    @(posedge clk);
    #1;
    rx = pin;
    if (rand_rdy) rx_ready = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1);
  endtask

  // rdy_at >= 0 drives rx_ready high only in that cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BITC; c++) begin
      drive_cycle(bits[c / BITC]);
      if (c == 0) begin
        ev_edge[wr_ptr] = cyc + LAT;
        ev_data[wr_ptr] = b;
        ev_ok[wr_ptr]   = stop;
        wr_ptr++;
      end
      if (rdy_at >= 0) rx_ready = (c == rdy_at);
    end
  endtask

  task automatic consume();
    drive_cycle(1'b1);
    rx_ready = 1'b1;
    drive_cycle(1'b1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int unsigned k;
    int          f0, o0, h0;
    logic [7:0]  b;
    logic        stop;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset frame_err", frame_err, 1'b0);
    check("reset overrun", overrun, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    // 1: 0xA5 held with rx_ready low, then consumed
    send_frame(8'hA5, 1'b1, -1);
    k = ev_edge[wr_ptr - 1] - LAT;
    idle(30);
    @(negedge clk);
    check("t1 latency within 154..158", ((rise_cyc - k) >= 154) && ((rise_cyc - k) <= 158), 1'b1);
    check("t1 rx_valid held", rx_valid, 1'b1);
    check("t1 rx_data", rx_data, 8'hA5);
    consume();
    @(negedge clk);
    check("t1 rx_valid after handshake", rx_valid, 1'b0);

    // 2: back-to-back 0x00, 0xFF with rx_ready tied high
    f0 = ferr_cnt; o0 = ovr_cnt; h0 = hs_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(30);
    check("t2 deliveries", hs_cnt - h0, 2);
    check("t2 last byte", hs_data, 8'hFF);
    check("t2 no flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    rx_ready = 1'b0;

    // 3: 4-clk glitch on an idle line, then 0x3C
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0);
    idle(40);
    @(negedge clk);
    check("t3 glitch no valid", rx_valid, 1'b0);
    check("t3 glitch no flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);
    @(negedge clk);
    check("t3 rx_data", rx_data, 8'h3C);
    consume();

    // 4: 0x5A with stop bit low, then 0x81
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, -1);
    idle(30);
    @(negedge clk);
    check("t4 frame_err cycles", ferr_cnt - f0, 1);
    check("t4 no delivery", rx_valid, 1'b0);
    send_frame(8'h81, 1'b1, -1);
    idle(20);
    @(negedge clk);
    check("t4 rx_data", rx_data, 8'h81);
    consume();

    // 5a: 0x11, 0x22 unconsumed -> overrun
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    @(negedge clk);
    check("t5a rx_data held", rx_data, 8'h11);
    check("t5a overrun cycles", ovr_cnt - o0, 1);
    consume();

    // 5b: handshake exactly on the second stop-decision cycle
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, LAT - 1);
    idle(20);
    @(negedge clk);
    check("t5b rx_data", rx_data, 8'h22);
    check("t5b no overrun", ovr_cnt - o0, 0);
    consume();

    // 6: reset during data bit 3 while the line is low
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'h00, 1'b1, -1);
      begin
        repeat (3 * BITC + 3 * BITC / 2 + 1 + BITC / 2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6 reset rx_valid", rx_valid, 1'b0);
        check("t6 reset rx_data", rx_data, 8'h00);
        check("t6 reset flags", {frame_err, overrun}, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(40);
    @(negedge clk);
    check("t6 no delivery after reset", rx_valid, 1'b0);
    check("t6 no flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'hC3, 1'b1, -1);
    idle(20);
    @(negedge clk);
    check("t6 rx_data", rx_data, 8'hC3);
    consume();

    // Randomized traffic with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, -1);
      if (stop) idle($urandom_range(0, 12));
      else      idle(20 + $urandom_range(0, 10));
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    idle(30);
    @(negedge clk);
    check("random drained", rx_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
